// File: rtl/serdes_link.sv
// serdes_link: start/stop framed serialiser and deserialiser with optional
// internal loopback. One bit per clock, LSB first.
//
// Build option: define SERDES_LINK_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit, and to check it on receive.
// Without it the frame is start + DATA_W data bits + stop.
//
// TX states
//   state  | meaning
//   IDLE   | line high, in_ready asserted, waiting for a word
//   START  | driving the start bit (0)
//   DATA   | driving data bit tx_cnt_q
//   PARITY | driving the even-parity bit (parity build only)
//   STOP   | driving the stop bit (1)
//
// RX states
//   state    | meaning
//   R_IDLE   | waiting for the line to drop (start bit)
//   R_DATA   | sampling data bit rx_cnt_q
//   R_PARITY | sampling the parity bit (parity build only)
//   R_STOP   | sampling the stop bit, publishing the word

module serdes_link #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  input  logic              des_in,
  input  logic              loop_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef SERDES_LINK_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PARITY, R_STOP} rx_state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_STOP} rx_state_e;
`endif

  tx_state_e         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d;
  logic              ser_out_q, ser_out_d;
`ifdef SERDES_LINK_PARITY_EN
  logic              tx_par_q, tx_par_d;
`endif

  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_err_q, out_err_d;
`ifdef SERDES_LINK_PARITY_EN
  logic              rx_par_q, rx_par_d;
`endif

  logic              rx_line;

  // Gating with nreset keeps in_ready low while reset is held, even though
  // the state register already reads IDLE.
  assign in_ready  = (tx_state_q == IDLE) && nreset;
  assign ser_out   = ser_out_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

  assign rx_line   = loop_en ? ser_out_q : des_in;

  // TX next state: ser_out_d is the bit that the line carries next cycle,
  // so the register output lines up with the state being entered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_word_d  = tx_word_q;
    ser_out_d  = 1'b1;
`ifdef SERDES_LINK_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          tx_word_d  = in_data;
`ifdef SERDES_LINK_PARITY_EN
          tx_par_d   = ^in_data;
`endif
          tx_cnt_d   = '0;
          ser_out_d  = 1'b0;
          tx_state_d = START;
        end
      end
      START: begin
        ser_out_d  = tx_word_q[0];
        tx_cnt_d   = '0;
        tx_state_d = DATA;
      end
      DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
`ifdef SERDES_LINK_PARITY_EN
          ser_out_d  = tx_par_q;
          tx_state_d = PARITY;
`else
          ser_out_d  = 1'b1;
          tx_state_d = STOP;
`endif
        end else begin
          // The word register shifts so bit 0 is always the bit on the line.
          ser_out_d  = tx_word_q[1];
          tx_word_d  = tx_word_q >> 1;
          tx_cnt_d   = tx_cnt_q + 1'b1;
        end
      end
`ifdef SERDES_LINK_PARITY_EN
      PARITY: begin
        ser_out_d  = 1'b1;
        tx_state_d = STOP;
      end
`endif
      STOP: begin
        ser_out_d  = 1'b1;
        tx_state_d = IDLE;
      end
      default: begin
        ser_out_d  = 1'b1;
        tx_state_d = IDLE;
      end
    endcase
  end

  // TX state register; reset drives the line idle-high immediately.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_word_q  <= '0;
      ser_out_q  <= 1'b1;
`ifdef SERDES_LINK_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_word_q  <= tx_word_d;
      ser_out_q  <= ser_out_d;
`ifdef SERDES_LINK_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // RX next state: shift LSB-first, publish the word on the stop slot.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_err_d   = 1'b0;
`ifdef SERDES_LINK_PARITY_EN
    rx_par_d    = rx_par_q;
`endif
    case (rx_state_q)
      R_IDLE: begin
        if (!rx_line) begin
          rx_cnt_d   = '0;
          rx_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rx_shift_d = {rx_line, rx_shift_q[DATA_W-1:1]};
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
`ifdef SERDES_LINK_PARITY_EN
          rx_state_d = R_PARITY;
`else
          rx_state_d = R_STOP;
`endif
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
`ifdef SERDES_LINK_PARITY_EN
      R_PARITY: begin
        rx_par_d   = rx_line;
        rx_state_d = R_STOP;
      end
`endif
      R_STOP: begin
        // A bad frame is still delivered; out_err flags it.
        out_data_d  = rx_shift_q;
        out_valid_d = 1'b1;
`ifdef SERDES_LINK_PARITY_EN
        out_err_d   = ~rx_line | (rx_par_q ^ (^rx_shift_q));
`else
        out_err_d   = ~rx_line;
`endif
        rx_state_d  = R_IDLE;
      end
      default: begin
        rx_state_d = R_IDLE;
      end
    endcase
  end

  // RX state register; reset drops any frame in progress.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
`ifdef SERDES_LINK_PARITY_EN
      rx_par_q    <= 1'b0;
`endif
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
`ifdef SERDES_LINK_PARITY_EN
      rx_par_q    <= rx_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serdes_link.sv
// Bench for serdes_link: an 8-bit and a 16-bit instance share clock and
// reset. Expected received words are queued when stimulus is driven and
// popped by per-instance monitors when out_valid fires.

module tb_serdes_link;

`ifdef SERDES_LINK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  in_data8;
  logic        in_valid8, in_ready8, ser_out8, des_in8, loop_en8;
  logic [7:0]  out_data8;
  logic        out_valid8, out_err8;

  logic [15:0] in_data16;
  logic        in_valid16, in_ready16, ser_out16, des_in16, loop_en16;
  logic [15:0] out_data16;
  logic        out_valid16, out_err16;

  serdes_link #(.DATA_W(8)) dut8 (
    .clk(clk), .nreset(nreset), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .ser_out(ser_out8), .des_in(des_in8),
    .loop_en(loop_en8), .out_data(out_data8), .out_valid(out_valid8),
    .out_err(out_err8)
  );

  serdes_link #(.DATA_W(16)) dut16 (
    .clk(clk), .nreset(nreset), .in_data(in_data16), .in_valid(in_valid16),
    .in_ready(in_ready16), .ser_out(ser_out16), .des_in(des_in16),
    .loop_en(loop_en16), .out_data(out_data16), .out_valid(out_valid16),
    .out_err(out_err16)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (out_valid8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid8: out_valid=1 data=%h at cycle %0d, none expected", out_data8, cyc);
      end else begin
        e = q8.pop_front();
        n_checks++;
        if (out_data8 !== e.data[7:0])
          $display("FAIL rx8_data: got %h expected %h", out_data8, e.data[7:0]);
        else n_pass++;
        n_checks++;
        if (out_err8 !== e.err)
          $display("FAIL rx8_err: got %b expected %b (data %h)", out_err8, e.err, e.data[7:0]);
        else n_pass++;
        n_checks++;
        if (cyc !== e.exp_cyc)
          $display("FAIL rx8_latency: out_valid at cycle %0d expected %0d", cyc, e.exp_cyc);
        else n_pass++;
      end
    end
  end

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin : mon16
    exp_t e;
    if (out_valid16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid16: out_valid=1 data=%h at cycle %0d", out_data16, cyc);
      end else begin
        e = q16.pop_front();
        n_checks++;
        if (out_data16 !== e.data[15:0])
          $display("FAIL rx16_data: got %h expected %h", out_data16, e.data[15:0]);
        else n_pass++;
        n_checks++;
        if (out_err16 !== e.err)
          $display("FAIL rx16_err: got %b expected %b", out_err16, e.err);
        else n_pass++;
        n_checks++;
        if (cyc !== e.exp_cyc)
          $display("FAIL rx16_latency: out_valid at cycle %0d expected %0d", cyc, e.exp_cyc);
        else n_pass++;
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send8(input logic [7:0] d, input bit expect_rx, output int t);
    int k;
    k = 0;
    in_data8  = d;
    in_valid8 = 1'b1;
    while (in_ready8 !== 1'b1 && k < 50) begin
      step(1);
      k++;
    end
    if (k >= 50) begin
      n_checks++;
      $display("FAIL send8_timeout: in_ready=%b after 50 cycles, expected 1", in_ready8);
      in_valid8 = 1'b0;
      t = -1;
    end else begin
      t = cyc;
      if (expect_rx)
        q8.push_back('{data: 32'(d), err: 1'b0, exp_cyc: t + 8 + 3 + PAR});
      step(1);
      in_valid8 = 1'b0;
      in_data8  = ~d;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q8.size() != 0 || q16.size() != 0) && k < 100) begin
      step(1);
      k++;
    end
    if (q8.size() != 0 || q16.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d/%0d frames outstanding, expected 0", q8.size(), q16.size());
      q8.delete();
      q16.delete();
    end
  endtask

  task automatic test_reset();
    in_data8 = '0;  in_valid8 = 1'b0;  des_in8 = 1'b1;  loop_en8 = 1'b1;
    in_data16 = '0; in_valid16 = 1'b0; des_in16 = 1'b1; loop_en16 = 1'b1;
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (ser_out8 !== 1'b1) $display("FAIL reset_ser_out: got %b expected 1", ser_out8); else n_pass++;
    n_checks++; if (in_ready8 !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready8); else n_pass++;
    n_checks++; if (out_data8 !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", out_data8); else n_pass++;
    n_checks++; if (out_valid8 !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid8); else n_pass++;
    n_checks++; if (out_err8 !== 1'b0) $display("FAIL reset_out_err: got %b expected 0", out_err8); else n_pass++;
    n_checks++; if (out_data16 !== 16'h0000) $display("FAIL reset_out_data16: got %h expected 0000", out_data16); else n_pass++;
    step(3);
    nreset = 1'b1;
    #1;
    n_checks++; if (in_ready8 !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready8); else n_pass++;
    step(1);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ser_out8 !== 1'b1) $display("FAIL idle_line: got %b expected 1", ser_out8); else n_pass++;
      step(1);
    end
  endtask

  task automatic test_loopback_a5();
    int t;
    logic [11:0] fr;
    int nbits;
    loop_en8 = 1'b1;
`ifdef SERDES_LINK_PARITY_EN
    fr = {2'b01, ^8'hA5, 8'hA5, 1'b0};
`else
    fr = {3'b011, 8'hA5, 1'b0};
`endif
    nbits = 10 + PAR;
    send8(8'hA5, 1'b1, t);
    in_data8 = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      n_checks++;
      if (ser_out8 !== fr[i])
        $display("FAIL a5_line_bit%0d: got %b expected %b", i, ser_out8, fr[i]);
      else n_pass++;
      step(1);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int t1, t2, k;
    loop_en8  = 1'b1;
    in_data8  = 8'h00;
    in_valid8 = 1'b1;
    k = 0;
    while (in_ready8 !== 1'b1 && k < 50) begin step(1); k++; end
    t1 = cyc;
    q8.push_back('{data: 32'h00, err: 1'b0, exp_cyc: t1 + 11 + PAR});
    step(1);
    in_data8 = 8'hFF;
    k = 0;
    while (in_ready8 !== 1'b1 && k < 50) begin step(1); k++; end
    t2 = cyc;
    q8.push_back('{data: 32'hFF, err: 1'b0, exp_cyc: t2 + 11 + PAR});
    n_checks++;
    if (t2 !== t1 + 11 + PAR) $display("FAIL b2b_gap: second handshake at %0d expected %0d", t2, t1 + 11 + PAR); else n_pass++;
    n_checks++;
    if (ser_out8 !== 1'b1) $display("FAIL b2b_idle_bit: got %b expected 1", ser_out8); else n_pass++;
    step(1);
    in_valid8 = 1'b0;
    n_checks++;
    if (ser_out8 !== 1'b0) $display("FAIL b2b_start_bit: got %b expected 0", ser_out8); else n_pass++;
    drain();
  endtask

  task automatic drive_frame8(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    logic err;
    err = ~stop_bit;
`ifdef SERDES_LINK_PARITY_EN
    err = err | (par_bit ^ (^d));
`endif
    q8.push_back('{data: 32'(d), err: err, exp_cyc: cyc + 8 + 2 + PAR});
    des_in8 = 1'b0;
    step(1);
    for (int i = 0; i < 8; i++) begin
      des_in8 = d[i];
      step(1);
    end
`ifdef SERDES_LINK_PARITY_EN
    des_in8 = par_bit;
    step(1);
`endif
    des_in8 = stop_bit;
    step(1);
    des_in8 = 1'b1;
  endtask

  task automatic test_loop_select();
    int t;
    loop_en8 = 1'b0;
    des_in8  = 1'b1;
    step(1);
    send8(8'h81, 1'b0, t);
    step(14);
    drive_frame8(8'h3C, ^8'h3C, 1'b0);
    drain();
    drive_frame8(8'h96, ^8'h96, 1'b1);
    drain();
  endtask

`ifdef SERDES_LINK_PARITY_EN
  task automatic test_parity();
    loop_en8 = 1'b0;
    des_in8  = 1'b1;
    step(1);
    drive_frame8(8'h01, 1'b0, 1'b1);
    drain();
    drive_frame8(8'h01, 1'b1, 1'b1);
    drain();
  endtask
`endif

  task automatic test_reset_mid();
    int t;
    loop_en8 = 1'b1;
    step(1);
    send8(8'hC3, 1'b0, t);
    step(5);
    n_checks++;
    if (ser_out8 !== 1'b0) $display("FAIL midrst_bit4: got %b expected 0", ser_out8); else n_pass++;
    nreset = 1'b0;
    #1;
    n_checks++;
    if (ser_out8 !== 1'b1) $display("FAIL midrst_line: got %b expected 1", ser_out8); else n_pass++;
    n_checks++;
    if (in_ready8 !== 1'b0) $display("FAIL midrst_ready: got %b expected 0", in_ready8); else n_pass++;
    step(2);
    nreset = 1'b1;
    #1;
    n_checks++;
    if (in_ready8 !== 1'b1) $display("FAIL midrst_release_ready: got %b expected 1", in_ready8); else n_pass++;
    step(15);
    send8(8'h5A, 1'b1, t);
    drain();
  endtask

  task automatic test_width16();
    int t, k;
    loop_en16  = 1'b1;
    in_data16  = 16'hBEEF;
    in_valid16 = 1'b1;
    k = 0;
    while (in_ready16 !== 1'b1 && k < 50) begin step(1); k++; end
    t = cyc;
    q16.push_back('{data: 32'hBEEF, err: 1'b0, exp_cyc: t + 19 + PAR});
    step(1);
    in_valid16 = 1'b0;
    in_data16  = 16'h0000;
    drain();
  endtask

  task automatic test_random();
    int t;
    logic [7:0] d;
    loop_en8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      send8(d, 1'b1, t);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_loopback_a5();
    test_back_to_back();
    test_loop_select();
`ifdef SERDES_LINK_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_width16();
    test_random();
    step(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serdes_link.md
SERDES_LINK -- requirements
Module: serdes_link

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the parallel word width in bits (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 nreset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_data  input  DATA_W  SHALL carry the word to serialise.
REQ-005 in_valid  input  1  SHALL indicate in_data is valid.
REQ-006 in_ready  output  1  SHALL indicate the serialiser accepts a word this cycle.
REQ-007 ser_out  output  1  SHALL be the registered serial line (idle high).
REQ-008 des_in  input  1  SHALL be the external serial input to the deserialiser.
REQ-009 loop_en  input  1  SHALL select ser_out (1) or des_in (0) as the deserialiser line, sampled every cycle.
REQ-010 out_data  output  DATA_W  SHALL hold the last received word.
REQ-011 out_valid  output  1  SHALL pulse high one cycle per received frame.
REQ-012 out_err  output  1  SHALL pulse with out_valid when the frame has a stop or parity error.

Function
REQ-013 Frame SHALL be: start bit 0, DATA_W data bits LSB first, optional parity bit (REQ-027), stop bit 1; one bit per clock.
REQ-014 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; in_ready SHALL be 1 only in IDLE.
REQ-015 Handshake SHALL occur in cycle T when in_valid && in_ready; in_data SHALL be captured at that edge and later changes ignored.
REQ-016 Start bit SHALL appear on ser_out in cycle T+1, data bit k in cycle T+2+k, stop bit after the last data or parity bit.
REQ-017 TX SHALL return to IDLE after STOP, giving at least one idle-high cycle between back-to-back frames.
REQ-018 in_valid without in_ready SHALL have no effect; in_valid low in IDLE SHALL keep ser_out high.
REQ-019 RX FSM SHALL have states R_IDLE, R_DATA, R_PARITY, R_STOP; R_IDLE SHALL leave on line == 0.
REQ-020 RX SHALL shift DATA_W bits LSB first with a bit counter of width clog2(DATA_W), wrapping to 0 at DATA_W-1.
REQ-021 On sampling the stop slot RX SHALL update out_data, assert out_valid the next cycle, and return to R_IDLE.
REQ-022 out_err SHALL be 1 if sampled stop bit is 0 or parity mismatches; out_data SHALL still update on error.
REQ-023 Loopback latency, handshake in cycle T to out_valid, SHALL be T+DATA_W+3 (+1 with parity).
REQ-024 TX and RX SHALL operate independently; a simultaneous handshake and RX completion SHALL both be honoured.

Reset
REQ-025 nreset low SHALL immediately force: TX IDLE, RX R_IDLE, ser_out=1, in_ready=0, out_data=0, out_valid=0, out_err=0, counters 0.
REQ-026 Reset mid-frame SHALL abandon both frames without emitting out_valid; in_ready SHALL rise the first cycle after nreset deasserts.

Configuration
REQ-027 Macro SERDES_LINK_PARITY_EN defined SHALL insert an even-parity bit (XOR of data bits) after the data and check it in RX; undefined SHALL omit the bit, the PARITY/R_PARITY states and the parity check, with out_err reflecting only the stop bit.

Verification
REQ-028 DATA_W=8, loop_en=1, send 8'hA5 at cycle T -> ser_out 0,1,0,1,0,0,1,0,1,1; out_data=8'hA5, out_valid at T+11 (T+12 with parity), out_err=0.
REQ-029 loop_en=1, in_valid held high with 8'h00 then 8'hFF -> one idle-high cycle between frames, two out_valid pulses, data 8'h00 then 8'hFF.
REQ-030 loop_en=0, drive des_in with frame for 8'h3C but stop bit 0 -> out_valid=1, out_err=1, out_data=8'h3C.
REQ-031 Parity enabled, drive des_in 8'h01 with parity bit 0 -> out_err=1; with parity bit 1 -> out_err=0.
REQ-032 nreset pulsed low during data bit 4 of 8'hC3 -> ser_out=1 immediately, no out_valid, next 8'h5A received correctly.
REQ-033 DATA_W=16, loopback 16'hBEEF -> out_data=16'hBEEF at T+19 (no parity).
